instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential program loader for the single-cycle ARM-subset core: it accepts instruction fields over a valid/ready handshake, encodes them into 32-bit instruction words, and writes them sequentially into instruction memory. It is the encoding counterpart of the main decoder, producing exactly the Op/I/L/funct layout the decoder consumes. It sits between the test/boot controller and the instruction-memory write port and is idle during normal execution.

## Interface
- ADDR_W, 6, instruction-memory word-address width (capacity 2^ADDR_W words)
- BASE_ADDR, 0, first word address written after start
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session (sampled only in IDLE or DONE)
- req_valid  in  1  field bundle valid
- req_ready  out  1  loader accepts a bundle this cycle
- op  in  2  0 data-processing, 1 memory, 2 branch, 3 illegal
- i_bit  in  1  DP: immediate Src2; MEM: immediate offset
- l_bit  in  1  MEM: 1 load, 0 store
- cond  in  4  condition field
- cmd  in  4  DP command; s_bit in 1 DP set-flags
- rn, rd  in  4 each  register fields
- src2  in  12  DP Src2 / MEM offset
- imm24  in  24  branch offset
- last  in  1  final instruction of the session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy, done, full, err  out  1 each  status (err sticky until next start)

## Operation
- Word layout: [31:28] cond, [27:26] op.
- DP: [25] i_bit, [24:21] cmd, [20] s_bit, [19:16] rn, [15:12] rd, [11:0] src2.
- MEM: [25] ~i_bit, [24:21] 4'b1100 (P=1,U=1,B=0,W=0), [20] l_bit, [19:16] rn, [15:12] rd, [11:0] src2.
- Branch: [25:24] 2'b10, [23:0] imm24.
- op=3: handshake completes, nothing written, err set, address unchanged.
- FSM states IDLE, ACCEPT, WRITE, DONE.
  - IDLE: start -> ACCEPT, addr=BASE_ADDR, err=0, full=0.
  - ACCEPT: req_ready=1; valid&legal -> WRITE; valid&illegal -> ACCEPT with err.
  - WRITE: imem_we=1 one cycle; then DONE if last or addr==2^ADDR_W-1 (set full in the latter case), else addr+1 -> ACCEPT.
  - DONE: done=1; start -> ACCEPT with re-initialised address and flags.
- start is ignored in ACCEPT and WRITE. Address never wraps. Writes beyond capacity are impossible.
- busy=1 in ACCEPT and WRITE.

## Timing
- Reset (async, any state): IDLE, req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=done=full=err=0. A write pending at reset is dropped.
- Handshake at edge N (req_valid&req_ready). imem_we, imem_addr, and imem_wdata are registered and valid for exactly cycle N+1. req_ready=0 during that cycle.
- Throughput is 1 word per 2 cycles. imem_wdata holds its last value outside WRITE.
- done/full assert the cycle after the final WRITE cycle.

## Structure
- Shared package: op codes (OP_DP=0, OP_MEM=1, OP_BR=2), FSM state encoding, MEM P/U/B/W constant, field bit positions.
- One combinational sub-module, instr_field_encoder: fields -> 32-bit word plus illegal flag. The top level holds the FSM, address counter, and output registers.

## Test plan
- DP: start; op0 i1 cond E cmd 4 s0 rn2 rd1 src2 5 -> imem_wdata 0xE2821005 at addr 0, we high one cycle.
- LDR/STR: op1 i1 l1 rn0 rd3 src2 8 -> 0xE5903008; same with l0 -> 0xE5803008 at addr+1.
- Branch: op2 cond E imm24 0xFFFFFE, last=1 -> 0xEAFFFFFE written, then done=1, busy=0.
- Illegal: op3 between two legal ops -> err=1, no we, following legal op lands at the next sequential address.
- Capacity: ADDR_W=2, five bundles with last=0 -> writes at 0..3, full=1, done=1, fifth bundle never accepted.
- Async reset during WRITE -> imem_we drops immediately, all outputs at reset values. A new start writes at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcode values, FSM
// state encoding, fixed MEM addressing bits and instruction field positions.
package instr_encoder_loader_pkg;

  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Memory ops are always pre-indexed, offset added, word-sized, no writeback.
  localparam logic [3:0] MEM_PUBW = 4'b1100;
  localparam logic [1:0] BR_TAG   = 2'b10;

  localparam int COND_LSB  = 28;
  localparam int OP_LSB    = 26;
  localparam int I_POS     = 25;
  localparam int CMD_LSB   = 21;
  localparam int S_POS     = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int BR_LSB    = 24;

endpackage

// File: rtl/instr_encoder_loader_field_encoder.sv
// Combinational packing of instruction fields into a 32-bit word in the
// layout the main decoder consumes; op=3 is flagged as illegal.
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        i_bit,
  input  logic        l_bit,
  input  logic [3:0]  cond,
  input  logic [3:0]  cmd,
  input  logic        s_bit,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[COND_LSB +: 4] = cond;
    word[OP_LSB +: 2]   = op;
    case (op)
      OP_DP: begin
        word[I_POS]         = i_bit;
        word[CMD_LSB +: 4]  = cmd;
        word[S_POS]         = s_bit;
        word[RN_LSB +: 4]   = rn;
        word[RD_LSB +: 4]   = rd;
        word[11:0]          = src2;
      end
      OP_MEM: begin
        // The decoder treats bit 25 set as a register offset, hence the inversion.
        word[I_POS]         = ~i_bit;
        word[CMD_LSB +: 4]  = MEM_PUBW;
        word[S_POS]         = l_bit;
        word[RN_LSB +: 4]   = rn;
        word[RD_LSB +: 4]   = rd;
        word[11:0]          = src2;
      end
      OP_BR: begin
        word[BR_LSB +: 2]   = BR_TAG;
        word[23:0]          = imm24;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Sequential program loader: accepts field bundles over valid/ready, encodes
// them and writes one word every two cycles into instruction memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic              i_bit,
  input  logic              l_bit,
  input  logic [3:0]        cond,
  input  logic [3:0]        cmd,
  input  logic              s_bit,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]  state;
  logic        last_q;
  logic [31:0] enc_word;
  logic        enc_illegal;

  instr_field_encoder u_enc (
    .op      (op),
    .i_bit   (i_bit),
    .l_bit   (l_bit),
    .cond    (cond),
    .cmd     (cmd),
    .s_bit   (s_bit),
    .rn      (rn),
    .rd      (rd),
    .src2    (src2),
    .imm24   (imm24),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign req_ready = (state == ST_ACCEPT);
  assign busy      = (state == ST_ACCEPT) || (state == ST_WRITE);
  assign done      = (state == ST_DONE);

  // imem_addr doubles as the session address counter; it only advances
  // after a write so it never wraps past the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      last_q     <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_ACCEPT;
            imem_addr <= BASE;
            err       <= 1'b0;
            full      <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (req_valid) begin
            if (enc_illegal) begin
              err <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_wdata <= enc_word;
              last_q     <= last;
              state      <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          imem_we <= 1'b0;
          if (last_q || (imem_addr == LAST_ADDR)) begin
            state <= ST_DONE;
            full  <= (imem_addr == LAST_ADDR);
          end else begin
            imem_addr <= imem_addr + 1'b1;
            state     <= ST_ACCEPT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a 4-word memory so the
// capacity limit is reachable; expected words are hand-encoded constants.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        op = '0;
  logic              i_bit = 1'b0;
  logic              l_bit = 1'b0;
  logic [3:0]        cond = '0;
  logic [3:0]        cmd = '0;
  logic              s_bit = 1'b0;
  logic [3:0]        rn = '0;
  logic [3:0]        rd = '0;
  logic [11:0]       src2 = '0;
  logic [23:0]       imm24 = '0;
  logic              last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, full, err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  prev_we = 1'b0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .i_bit      (i_bit),
    .l_bit      (l_bit),
    .cond       (cond),
    .cmd        (cmd),
    .s_bit      (s_bit),
    .rn         (rn),
    .rd         (rd),
    .src2       (src2),
    .imm24      (imm24),
    .last       (last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      check_output("we_single_cycle", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("write_addr", 32'(imem_addr), e.addr);
        check_output("write_data", imem_wdata, e.data);
      end
    end
    prev_we = imem_we;
  end

  task automatic apply_stimulus(
    input logic [1:0] f_op, input logic f_i, input logic f_l, input logic [3:0] f_cond,
    input logic [3:0] f_cmd, input logic f_s, input logic [3:0] f_rn, input logic [3:0] f_rd,
    input logic [11:0] f_src2, input logic [23:0] f_imm, input logic f_last,
    input bit expect_write, input logic [31:0] exp_addr, input logic [31:0] exp_word,
    output bit accepted);
    bit ready_seen;
    accepted = 1'b0;
    @(negedge clk);
    op = f_op; i_bit = f_i; l_bit = f_l; cond = f_cond; cmd = f_cmd; s_bit = f_s;
    rn = f_rn; rd = f_rd; src2 = f_src2; imm24 = f_imm; last = f_last;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ready_seen = req_ready;
      if (ready_seen && expect_write) begin
        wr_t e;
        e.addr = exp_addr;
        e.data = exp_word;
        exp_q.push_back(e);
      end
      @(posedge clk);
      if (ready_seen) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;

    repeat (3) @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_we", 32'(imem_we), 32'd0);
    check_output("rst_addr", 32'(imem_addr), 32'd0);
    check_output("rst_wdata", imem_wdata, 32'd0);
    check_output("rst_status", {28'd0, busy, done, full, err}, 32'd0);
    reset_n = 1'b1;

    // Session 1: DP, illegal, LDR, branch with last.
    pulse_start();
    check_output("s1_busy", 32'(busy), 32'd1);
    check_output("s1_ready", 32'(req_ready), 32'd1);
    apply_stimulus(2'd0, 1'b1, 1'b0, 4'hE, 4'd4, 1'b0, 4'd2, 4'd1, 12'd5, 24'd0, 1'b0,
                   1'b1, 32'd0, 32'hE2821005, acc);
    check_output("dp_accepted", 32'(acc), 32'd1);
    check_output("write_cycle_not_ready", 32'(req_ready), 32'd0);
    apply_stimulus(2'd3, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'd0, 24'd0, 1'b0,
                   1'b0, 32'd0, 32'd0, acc);
    check_output("illegal_accepted", 32'(acc), 32'd1);
    check_output("illegal_err", 32'(err), 32'd1);
    check_output("illegal_still_ready", 32'(req_ready), 32'd1);
    apply_stimulus(2'd1, 1'b1, 1'b1, 4'hE, 4'd0, 1'b0, 4'd0, 4'd3, 12'd8, 24'd0, 1'b0,
                   1'b1, 32'd1, 32'hE5903008, acc);
    apply_stimulus(2'd2, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'd0, 24'hFFFFFE, 1'b1,
                   1'b1, 32'd2, 32'hEAFFFFFE, acc);
    wait_done();
    check_output("s1_done", 32'(done), 32'd1);
    check_output("s1_busy_low", 32'(busy), 32'd0);
    check_output("s1_full", 32'(full), 32'd0);
    check_output("s1_err_sticky", 32'(err), 32'd1);
    check_output("s1_wdata_hold", imem_wdata, 32'hEAFFFFFE);

    // Session 2: restart from DONE, then fill all four words.
    pulse_start();
    check_output("s2_err_cleared", 32'(err), 32'd0);
    check_output("s2_addr_base", 32'(imem_addr), 32'd0);
    apply_stimulus(2'd1, 1'b1, 1'b0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd3, 12'd8, 24'd0, 1'b0,
                   1'b1, 32'd0, 32'hE5803008, acc);
    apply_stimulus(2'd0, 1'b1, 1'b0, 4'hE, 4'd4, 1'b0, 4'd2, 4'd1, 12'd5, 24'd0, 1'b0,
                   1'b1, 32'd1, 32'hE2821005, acc);
    apply_stimulus(2'd0, 1'b0, 1'b0, 4'h0, 4'd2, 1'b1, 4'd7, 4'd9, 12'h003, 24'd0, 1'b0,
                   1'b1, 32'd2, 32'h00579003, acc);
    apply_stimulus(2'd1, 1'b0, 1'b1, 4'h1, 4'd0, 1'b0, 4'd5, 4'd6, 12'h004, 24'd0, 1'b0,
                   1'b1, 32'd3, 32'h17956004, acc);
    apply_stimulus(2'd2, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'd0, 24'h000010, 1'b0,
                   1'b0, 32'd0, 32'd0, acc);
    check_output("fifth_not_accepted", 32'(acc), 32'd0);
    check_output("cap_full", 32'(full), 32'd1);
    check_output("cap_done", 32'(done), 32'd1);
    check_output("cap_addr_no_wrap", 32'(imem_addr), 32'd3);

    // Session 3: async reset while the write strobe is high.
    pulse_start();
    apply_stimulus(2'd0, 1'b1, 1'b0, 4'hE, 4'd4, 1'b0, 4'd2, 4'd1, 12'd5, 24'd0, 1'b0,
                   1'b0, 32'd0, 32'd0, acc);
    check_output("pre_reset_we", 32'(imem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("arst_we", 32'(imem_we), 32'd0);
    check_output("arst_addr", 32'(imem_addr), 32'd0);
    check_output("arst_wdata", imem_wdata, 32'd0);
    check_output("arst_status", {27'd0, req_ready, busy, done, full, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start();
    apply_stimulus(2'd2, 1'b0, 1'b0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'd0, 24'hFFFFFE, 1'b1,
                   1'b1, 32'd0, 32'hEAFFFFFE, acc);
    wait_done();
    check_output("s3_done", 32'(done), 32'd1);

    repeat (2) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
